obstacle_scroll_bank: RTL

OBSTACLE_SCROLL_BANK -- requirements
Module: obstacle_scroll_bank

---
 rtl/obstacle_scroll_bank_if.sv | 27 ++
 rtl/obstacle_scroll_bank.sv | 135 +++++++++++++
 2 files changed

// File: rtl/obstacle_scroll_bank_if.sv
// Column feed handshake into the scroll bank and the column stream leaving it on each tick.
// master drives col_in/col_valid; slave is the scroll bank.
interface obstacle_scroll_bank_if #(
  parameter int unsigned ROWS = 30
) ();
  logic [ROWS-1:0] col_in;
  logic            col_valid;
  logic            col_ready;
  logic [ROWS-1:0] out_col;
  logic            out_valid;

  modport master (
    output col_in,
    output col_valid,
    input  col_ready,
    input  out_col,
    input  out_valid
  );

  modport slave (
    input  col_in,
    input  col_valid,
    output col_ready,
    output out_col,
    output out_valid
  );
endinterface

// File: rtl/obstacle_scroll_bank.sv
// ROWS x COLS obstacle grid scrolled left one column per divider tick, fed from a one-entry stage.
// Define OBSTACLE_GEN_EN to fill underrun columns with an LFSR-placed gap instead of all zeros.
module obstacle_scroll_bank #(
  parameter int unsigned ROWS     = 30,
  parameter int unsigned COLS     = 40,
  parameter int unsigned TICK_DIV = 833333,
  parameter int unsigned GAP_H    = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    mode,
  obstacle_scroll_bank_if.slave   col_bus,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic                    rd_bit,
  output logic                    tick,
  output logic                    underrun,
  input  logic                    underrun_clr
);

  if (ROWS < 2 || ROWS > 64 || COLS < 2 || COLS > 64 || TICK_DIV < 2 ||
      GAP_H < 1 || GAP_H >= ROWS) begin : g_param_check
    $error("obstacle_scroll_bank: parameter out of range");
  end

  localparam int unsigned     CntW   = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0]           cnt_q;
  logic [COLS-1:0][ROWS-1:0] grid_q;
  logic [ROWS-1:0]           stage_q;
  logic                      stage_full_q;
  logic [ROWS-1:0]           out_col_q;
  logic                      out_valid_q;
  logic                      underrun_q;
  logic                      rd_bit_q;

  logic [ROWS-1:0] push_col;
  logic [ROWS-1:0] fill_col;
  logic            feed_tick;
  logic            fill_used;
  logic            col_ready;
  logic            col_load;
  logic            rd_in_range;

  assign tick        = enable & (cnt_q == CntMax);
  assign feed_tick   = tick & ~mode;
  assign fill_used   = feed_tick & ~stage_full_q;
  // A feed tick frees the slot in the same cycle; the new column lands after the old one leaves.
  assign col_ready   = ~stage_full_q | feed_tick;
  assign col_load    = col_bus.col_valid & col_ready;
  assign rd_in_range = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);

  assign col_bus.col_ready = col_ready;
  assign col_bus.out_col   = out_col_q;
  assign col_bus.out_valid = out_valid_q;
  assign rd_bit            = rd_bit_q;
  assign underrun          = underrun_q;

  always_comb begin
    push_col = fill_col;
    if (mode) begin
      push_col = grid_q[0];
    end else if (stage_full_q) begin
      push_col = stage_q;
    end
  end

`ifdef OBSTACLE_GEN_EN
  localparam int unsigned GapSpan = ROWS - GAP_H + 1;

  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [7:0]  gap_base;

  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign gap_base = 8'(32'(lfsr_q[15:8]) % GapSpan);

  always_comb begin
    fill_col = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if ((r >= 32'(gap_base)) && (r < 32'(gap_base) + GAP_H)) begin
        fill_col[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      lfsr_q <= 16'hACE1;
    end else if (fill_used) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  assign fill_col = '0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cnt_q        <= '0;
      grid_q       <= '0;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      out_col_q    <= '0;
      out_valid_q  <= 1'b0;
      underrun_q   <= 1'b0;
      rd_bit_q     <= 1'b0;
    end else begin
      if (enable) begin
        cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
      out_valid_q <= tick;
      // Sampled from grid_q before any shift this edge, so a read on a tick sees pre-shift data.
      rd_bit_q    <= rd_in_range & grid_q[rd_col][rd_row];
      if (tick) begin
        grid_q    <= {push_col, grid_q[COLS-1:1]};
        out_col_q <= grid_q[0];
      end
      if (col_load) begin
        stage_q      <= col_bus.col_in;
        stage_full_q <= 1'b1;
      end else if (feed_tick) begin
        stage_full_q <= 1'b0;
      end
      if (fill_used) begin
        underrun_q <= 1'b1;
      end else if (underrun_clr) begin
        underrun_q <= 1'b0;
      end
    end
  end

endmodule
